// File: rtl/uart_buf_pkg.sv
// Shared definitions for the UART byte packer: state encoding, SRAM
// constants and the word payload layout.
package uart_buf_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned ADDR_W = 16;

    // SRAM direction encoding; the packer only ever writes.
    localparam logic SRAM_RW_WRITE = 1'b0;

    // Packer FSM states.
    typedef enum logic [2:0] {
        ST_COLLECT   = 3'd0,
        ST_REQ       = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_SWITCH    = 3'd4
    } packer_state_t;

    // One SRAM word: first received byte in the upper half.
    typedef struct packed {
        logic [BYTE_W-1:0] hi;
        logic [BYTE_W-1:0] lo;
    } sram_word_t;

    // Build an SRAM word from an ordered byte pair.
    function automatic logic [WORD_W-1:0] pack_word(
        input logic [BYTE_W-1:0] hi,
        input logic [BYTE_W-1:0] lo
    );
        sram_word_t w;
        w.hi = hi;
        w.lo = lo;
        return w;
    endfunction

endpackage

// File: rtl/uart_byte_packer.sv
// UART byte packer: pairs received bytes into 16-bit words and writes them
// to a ping-pong SRAM buffer, pulsing switch when a buffer fills.
// Optional macro PACKER_FLUSH_EN: flush a lone pending byte (low byte 0x00)
// after FLUSH_CYCLES idle cycles.
module uart_byte_packer
    import uart_buf_pkg::*;
#(
    parameter int unsigned BUF_DEPTH    = 87,
    parameter int unsigned FLUSH_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic              sram_ready,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [WORD_W-1:0] sram_data,
    output logic              sram_rw,
    output logic              sram_start,
    output logic              switch,
    output logic              overflow
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BUF_DEPTH - 1);

    // Reject parameter values the address counter or flush timer cannot honour.
    if (BUF_DEPTH < 1 || BUF_DEPTH > (1 << ADDR_W) || FLUSH_CYCLES < 1) begin : g_bad_params
        $error("uart_byte_packer: BUF_DEPTH must be 1..65536 and FLUSH_CYCLES >= 1");
    end

    packer_state_t     r_state;
    packer_state_t     w_state_n;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_n;
    logic [WORD_W-1:0] r_data;
    logic [WORD_W-1:0] w_data_n;
    logic              r_start;
    logic              w_start_n;
    logic              r_switch;
    logic              w_switch_n;
    logic              r_overflow;
    logic              w_overflow_n;
    logic              r_pending;
    logic              w_pending_n;
    logic [BYTE_W-1:0] r_hi;
    logic [BYTE_W-1:0] w_hi_n;
    logic              r_hold_valid;
    logic              w_hold_valid_n;
    logic [BYTE_W-1:0] r_hold_data;
    logic [BYTE_W-1:0] w_hold_data_n;

    logic              w_take;
    logic [BYTE_W-1:0] w_byte;

`ifdef PACKER_FLUSH_EN
    localparam int unsigned FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    logic [FLUSH_W-1:0] r_flush_cnt;
    logic               w_flush_idle;
    logic               w_flush_fire;

    // A half-filled pair with no byte arriving or waiting counts as idle.
    assign w_flush_idle = (r_state == ST_COLLECT) && r_pending && !rx_valid && !r_hold_valid;
    assign w_flush_fire = w_flush_idle && (r_flush_cnt == FLUSH_W'(FLUSH_CYCLES - 1));

    // Consecutive idle-cycle counter for the pending byte; any activity restarts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flush_cnt <= '0;
        end else if (!w_flush_idle || w_flush_fire) begin
            r_flush_cnt <= '0;
        end else begin
            r_flush_cnt <= r_flush_cnt + FLUSH_W'(1);
        end
    end
`endif

    // Byte intake: held byte has priority in COLLECT; outside COLLECT bytes park
    // in the one-entry holding register, and a byte finding it full is lost.
    always_comb begin
        w_take         = 1'b0;
        w_byte         = '0;
        w_hold_valid_n = r_hold_valid;
        w_hold_data_n  = r_hold_data;
        w_overflow_n   = r_overflow;
        if (r_state == ST_COLLECT) begin
            if (r_hold_valid) begin
                w_take         = 1'b1;
                w_byte         = r_hold_data;
                w_hold_valid_n = rx_valid;
                if (rx_valid) begin
                    w_hold_data_n = rx_data;
                end
            end else if (rx_valid) begin
                w_take = 1'b1;
                w_byte = rx_data;
            end
        end else if (rx_valid) begin
            if (!r_hold_valid) begin
                w_hold_valid_n = 1'b1;
                w_hold_data_n  = rx_data;
            end else begin
                w_overflow_n = 1'b1;
            end
        end
    end

    // Next-state and registered-output logic for the write handshake.
    always_comb begin
        w_state_n   = r_state;
        w_addr_n    = r_addr;
        w_data_n    = r_data;
        w_start_n   = 1'b1;
        w_switch_n  = 1'b0;
        w_pending_n = r_pending;
        w_hi_n      = r_hi;
        case (r_state)
            ST_COLLECT: begin
                if (w_take) begin
                    if (r_pending) begin
                        w_data_n    = pack_word(r_hi, w_byte);
                        w_pending_n = 1'b0;
                        w_state_n   = ST_REQ;
                        w_start_n   = !sram_ready;
                    end else begin
                        w_hi_n      = w_byte;
                        w_pending_n = 1'b1;
                    end
                end
`ifdef PACKER_FLUSH_EN
                else if (w_flush_fire) begin
                    w_data_n    = pack_word(r_hi, BYTE_W'(0));
                    w_pending_n = 1'b0;
                    w_state_n   = ST_REQ;
                    w_start_n   = !sram_ready;
                end
`endif
            end
            ST_REQ: begin
                // Strobe low this cycle means the request is out; otherwise
                // keep retrying until the controller reports idle.
                if (!r_start) begin
                    w_state_n = ST_WAIT_BUSY;
                end else begin
                    w_start_n = !sram_ready;
                end
            end
            ST_WAIT_BUSY: begin
                if (!sram_ready) begin
                    w_state_n = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (sram_ready) begin
                    if (r_addr == LAST_ADDR) begin
                        w_state_n  = ST_SWITCH;
                        w_switch_n = 1'b1;
                    end else begin
                        w_addr_n  = r_addr + ADDR_W'(1);
                        w_state_n = ST_COLLECT;
                    end
                end
            end
            ST_SWITCH: begin
                w_addr_n  = '0;
                w_state_n = ST_COLLECT;
            end
            default: begin
                w_state_n = ST_COLLECT;
            end
        endcase
    end

    // State and output registers; reset abandons any word in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_COLLECT;
            r_addr       <= '0;
            r_data       <= '0;
            r_start      <= 1'b1;
            r_switch     <= 1'b0;
            r_overflow   <= 1'b0;
            r_pending    <= 1'b0;
            r_hi         <= '0;
            r_hold_valid <= 1'b0;
            r_hold_data  <= '0;
        end else begin
            r_state      <= w_state_n;
            r_addr       <= w_addr_n;
            r_data       <= w_data_n;
            r_start      <= w_start_n;
            r_switch     <= w_switch_n;
            r_overflow   <= w_overflow_n;
            r_pending    <= w_pending_n;
            r_hi         <= w_hi_n;
            r_hold_valid <= w_hold_valid_n;
            r_hold_data  <= w_hold_data_n;
        end
    end

    assign sram_addr  = r_addr;
    assign sram_data  = r_data;
    assign sram_rw    = SRAM_RW_WRITE;
    assign sram_start = r_start;
    assign switch     = r_switch;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_uart_byte_packer.sv
// Self-checking bench for uart_byte_packer with a behavioural SRAM controller.
module tb_uart_byte_packer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned FLUSH = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        sram_ready;
    logic [15:0] sram_addr;
    logic [15:0] sram_data;
    logic        sram_rw;
    logic        sram_start;
    logic        switch;
    logic        overflow;

    int n_tests = 0;
    int n_fail  = 0;

    // SRAM controller model knobs and state
    int busy_len   = 2;
    int drop_delay = 0;
    int ph;
    int cnt;

    // Monitor results
    logic [15:0] wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    int          sw_at_q[$];
    int          sw_cnt    = 0;
    int          sw_wide   = 0;
    int          proto_err = 0;
    bit          prev_sw   = 1'b0;

    always #5 clk = ~clk;

    uart_byte_packer #(
        .BUF_DEPTH   (DEPTH),
        .FLUSH_CYCLES(FLUSH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .sram_ready(sram_ready),
        .sram_addr (sram_addr),
        .sram_data (sram_data),
        .sram_rw   (sram_rw),
        .sram_start(sram_start),
        .switch    (switch),
        .overflow  (overflow)
    );

    // SRAM controller: idle=ready; on a start strobe optionally stays ready for
    // drop_delay cycles, then is busy for busy_len cycles.
    always @(posedge clk) begin
        if (reset) begin
            sram_ready <= 1'b1;
            ph         <= 0;
            cnt        <= 0;
        end else begin
            case (ph)
                0: if (sram_start === 1'b0) begin
                    if (drop_delay == 0) begin
                        sram_ready <= 1'b0;
                        ph         <= 2;
                        cnt        <= busy_len;
                    end else begin
                        ph  <= 1;
                        cnt <= drop_delay;
                    end
                end
                1: if (cnt <= 1) begin
                    sram_ready <= 1'b0;
                    ph         <= 2;
                    cnt        <= busy_len;
                end else begin
                    cnt <= cnt - 1;
                end
                default: if (cnt <= 1) begin
                    sram_ready <= 1'b1;
                    ph         <= 0;
                end else begin
                    cnt <= cnt - 1;
                end
            endcase
        end
    end

    // Monitor on the falling edge: record write strobes and switch pulses.
    always @(negedge clk) begin
        if (!reset) begin
            if (sram_start === 1'b0) begin
                wr_addr_q.push_back(sram_addr);
                wr_data_q.push_back(sram_data);
                if (sram_ready !== 1'b1) proto_err++;
            end
            if (switch === 1'b1) begin
                sw_cnt++;
                sw_at_q.push_back(wr_addr_q.size());
                if (prev_sw) sw_wide++;
            end
            prev_sw = (switch === 1'b1);
        end else begin
            prev_sw = 1'b0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        cyc(1);
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        rx_valid = 1'b0;
        cyc(2);
        reset = 1'b0;
        cyc(1);
        wr_addr_q.delete();
        wr_data_q.delete();
        sw_at_q.delete();
        sw_cnt = 0;
    endtask

    task automatic wait_wr(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (wr_addr_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            cyc(1);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'hFF;
        cyc(3);
        @(negedge clk);
        n_tests++; if (sram_start !== 1'b1) begin n_fail++; $display("FAIL reset_start got %b need 1", sram_start); end
        n_tests++; if (sram_addr !== 16'h0) begin n_fail++; $display("FAIL reset_addr got %h need 0000", sram_addr); end
        n_tests++; if (sram_data !== 16'h0) begin n_fail++; $display("FAIL reset_data got %h need 0000", sram_data); end
        n_tests++; if (sram_rw !== 1'b0) begin n_fail++; $display("FAIL reset_rw got %b need 0", sram_rw); end
        n_tests++; if (switch !== 1'b0) begin n_fail++; $display("FAIL reset_switch got %b need 0", switch); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b need 0", overflow); end
        cyc(1);
        rx_valid = 1'b0;
        reset    = 1'b0;
        cyc(4);
        @(negedge clk);
        n_tests++; if (sram_start !== 1'b1) begin n_fail++; $display("FAIL post_reset_start got %b need 1", sram_start); end
        cyc(1);
        wr_addr_q.delete();
        wr_data_q.delete();
        sw_at_q.delete();
        sw_cnt    = 0;
        sw_wide   = 0;
        proto_err = 0;
    endtask

    task automatic test_single_word();
        bit ok;
        do_reset();
        busy_len   = 3;
        drop_delay = 0;
        send(8'hA5);
        rx_valid = 1'b1;
        rx_data  = 8'h3C;
        @(negedge clk);
        n_tests++; if (sram_start !== 1'b1) begin n_fail++; $display("FAIL single_start_early got %b need 1", sram_start); end
        cyc(1);
        rx_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (sram_start !== 1'b0) begin n_fail++; $display("FAIL single_start_latency got %b need 0", sram_start); end
        n_tests++; if (sram_data !== 16'hA53C) begin n_fail++; $display("FAIL single_data got %h need a53c", sram_data); end
        n_tests++; if (sram_addr !== 16'h0) begin n_fail++; $display("FAIL single_addr got %h need 0000", sram_addr); end
        cyc(1);
        @(negedge clk);
        n_tests++; if (sram_start !== 1'b1) begin n_fail++; $display("FAIL single_start_width got %b need 1", sram_start); end
        wait_wr(1, 50, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL single_timeout got no write need 1 write"); end
        cyc(12);
        n_tests++; if (wr_addr_q.size() != 1) begin n_fail++; $display("FAIL single_count got %0d need 1", wr_addr_q.size()); end
        n_tests++; if (sram_addr !== 16'd1) begin n_fail++; $display("FAIL single_next_addr got %h need 0001", sram_addr); end
    endtask

    task automatic test_rotation();
        logic [7:0]  b0, b1;
        logic [15:0] exp_d[$];
        bit ok;
        do_reset();
        busy_len   = int'($urandom_range(1, 4));
        drop_delay = 0;
        for (int i = 0; i < 4; i++) begin
            b0 = 8'($urandom);
            b1 = 8'($urandom);
            exp_d.push_back({b0, b1});
            send(b0);
            send(b1);
            cyc(busy_len + 8);
        end
        wait_wr(4, 100, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL rot_timeout got %0d writes need 4", wr_addr_q.size()); end
        cyc(20);
        n_tests++; if (wr_addr_q.size() != 4) begin n_fail++; $display("FAIL rot_count got %0d need 4", wr_addr_q.size()); end
        for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
            n_tests++; if (wr_addr_q[i] !== 16'(i)) begin n_fail++; $display("FAIL rot_addr[%0d] got %h need %h", i, wr_addr_q[i], 16'(i)); end
            n_tests++; if (wr_data_q[i] !== exp_d[i]) begin n_fail++; $display("FAIL rot_data[%0d] got %h need %h", i, wr_data_q[i], exp_d[i]); end
        end
        n_tests++; if (sw_cnt != 1) begin n_fail++; $display("FAIL rot_switch_count got %0d need 1", sw_cnt); end
        if (sw_at_q.size() > 0) begin
            n_tests++; if (sw_at_q[0] != 4) begin n_fail++; $display("FAIL rot_switch_after got %0d writes need 4", sw_at_q[0]); end
        end
        n_tests++; if (sram_addr !== 16'h0) begin n_fail++; $display("FAIL rot_addr_wrap got %h need 0000", sram_addr); end
    endtask

    // Random pairs, spaced so the holding register never overflows.
    task automatic test_random();
        logic [7:0]  b0, b1;
        logic [15:0] exp_a[$];
        logic [15:0] exp_d[$];
        int g1, g2, npairs;
        bit ok;
        do_reset();
        busy_len   = int'($urandom_range(1, 6));
        drop_delay = 0;
        npairs     = 10;
        for (int i = 0; i < npairs; i++) begin
            b0 = 8'($urandom);
            b1 = 8'($urandom);
            exp_a.push_back(16'(i % DEPTH));
            exp_d.push_back({b0, b1});
            g1 = int'($urandom_range(0, busy_len + 5));
            g2 = int'($urandom_range(0, 3));
            if (g1 + g2 < busy_len + 5) g2 = busy_len + 5 - g1;
            cyc(g1);
            send(b0);
            cyc(g2);
            send(b1);
        end
        wait_wr(npairs, 400, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL rand_timeout got %0d writes need %0d", wr_addr_q.size(), npairs); end
        cyc(busy_len + 12);
        n_tests++; if (wr_addr_q.size() != npairs) begin n_fail++; $display("FAIL rand_count got %0d need %0d", wr_addr_q.size(), npairs); end
        for (int i = 0; i < npairs && i < wr_addr_q.size(); i++) begin
            n_tests++; if (wr_addr_q[i] !== exp_a[i] || wr_data_q[i] !== exp_d[i]) begin
                n_fail++; $display("FAIL rand_write[%0d] got %h@%h need %h@%h", i, wr_data_q[i], wr_addr_q[i], exp_d[i], exp_a[i]);
            end
        end
        n_tests++; if (sw_cnt != npairs / DEPTH) begin n_fail++; $display("FAIL rand_switch_count got %0d need %0d", sw_cnt, npairs / DEPTH); end
        n_tests++; if (sram_addr !== 16'(npairs % DEPTH)) begin n_fail++; $display("FAIL rand_final_addr got %h need %h", sram_addr, 16'(npairs % DEPTH)); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rand_overflow got %b need 0", overflow); end
    endtask

    // Third byte is held during the write; fourth lands exactly as COLLECT resumes.
    task automatic test_back_to_back();
        logic [7:0] b0, b1, b2, b3;
        bit ok;
        do_reset();
        busy_len   = 1;
        drop_delay = 0;
        b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
        rx_valid = 1'b1;
        rx_data  = b0; cyc(1);
        rx_data  = b1; cyc(1);
        rx_data  = b2; cyc(1);
        rx_valid = 1'b0;
        cyc(2);
        send(b3);
        wait_wr(2, 60, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL b2b_timeout got %0d writes need 2", wr_addr_q.size()); end
        cyc(10);
        if (wr_data_q.size() >= 2) begin
            n_tests++; if (wr_data_q[0] !== {b0, b1} || wr_addr_q[0] !== 16'd0) begin
                n_fail++; $display("FAIL b2b_first got %h@%h need %h@0000", wr_data_q[0], wr_addr_q[0], {b0, b1});
            end
            n_tests++; if (wr_data_q[1] !== {b2, b3} || wr_addr_q[1] !== 16'd1) begin
                n_fail++; $display("FAIL b2b_second got %h@%h need %h@0001", wr_data_q[1], wr_addr_q[1], {b2, b3});
            end
        end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_overflow got %b need 0", overflow); end
    endtask

    task automatic test_overflow();
        bit ok;
        do_reset();
        busy_len   = 50;
        drop_delay = 0;
        send(8'h12);
        send(8'h34);
        cyc(5);
        send(8'h56);
        cyc(2);
        @(negedge clk);
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_held_only got %b need 0", overflow); end
        cyc(1);
        send(8'h9A);
        @(negedge clk);
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b need 1", overflow); end
        cyc(1);
        send(8'hBC);
        @(negedge clk);
        n_tests++; if (sram_data !== 16'h1234) begin n_fail++; $display("FAIL ovf_data_stable got %h need 1234", sram_data); end
        n_tests++; if (sram_start !== 1'b1) begin n_fail++; $display("FAIL ovf_start_idle got %b need 1", sram_start); end
        cyc(60);
        n_tests++; if (wr_addr_q.size() != 1) begin n_fail++; $display("FAIL ovf_one_write got %0d need 1", wr_addr_q.size()); end
        send(8'hDE);
        wait_wr(2, 20, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL ovf_timeout got %0d writes need 2", wr_addr_q.size()); end
        cyc(60);
        if (wr_data_q.size() >= 2) begin
            n_tests++; if (wr_data_q[1] !== 16'h56DE || wr_addr_q[1] !== 16'd1) begin
                n_fail++; $display("FAIL ovf_held_word got %h@%h need 56de@0001", wr_data_q[1], wr_addr_q[1]);
            end
        end
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b need 1", overflow); end
        reset = 1'b1;
        cyc(1);
        @(negedge clk);
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_reset_clear got %b need 0", overflow); end
        cyc(1);
        reset = 1'b0;
        cyc(1);
    endtask

    task automatic test_flush();
        bit ok;
        do_reset();
        busy_len   = 2;
        drop_delay = 0;
        send(8'h7E);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            n_tests++; if (sram_start !== 1'b1) begin n_fail++; $display("FAIL flush_idle[%0d] got %b need 1", k, sram_start); end
            cyc(1);
        end
        @(negedge clk);
`ifdef PACKER_FLUSH_EN
        n_tests++; if (sram_start !== 1'b0) begin n_fail++; $display("FAIL flush_start got %b need 0", sram_start); end
        n_tests++; if (sram_data !== 16'h7E00) begin n_fail++; $display("FAIL flush_data got %h need 7e00", sram_data); end
        cyc(30);
        n_tests++; if (wr_addr_q.size() != 1) begin n_fail++; $display("FAIL flush_count got %0d need 1", wr_addr_q.size()); end
        n_tests++; if (sram_addr !== 16'd1) begin n_fail++; $display("FAIL flush_next_addr got %h need 0001", sram_addr); end
`else
        n_tests++; if (sram_start !== 1'b1) begin n_fail++; $display("FAIL noflush_start got %b need 1", sram_start); end
        cyc(30);
        n_tests++; if (wr_addr_q.size() != 0) begin n_fail++; $display("FAIL noflush_count got %0d need 0", wr_addr_q.size()); end
        send(8'h11);
        wait_wr(1, 20, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL noflush_timeout got no write need 1 write"); end
        cyc(10);
        if (wr_data_q.size() >= 1) begin
            n_tests++; if (wr_data_q[0] !== 16'h7E11 || wr_addr_q[0] !== 16'd0) begin
                n_fail++; $display("FAIL noflush_pair got %h@%h need 7e11@0000", wr_data_q[0], wr_addr_q[0]);
            end
        end
`endif
    endtask

    // Reset while the last word of a buffer sits in WAIT_BUSY.
    task automatic test_reset_mid();
        logic [7:0] b0, b1;
        bit ok;
        do_reset();
        busy_len   = 3;
        drop_delay = 0;
        for (int i = 0; i < 3; i++) begin
            send(8'($urandom));
            send(8'($urandom));
            cyc(15);
        end
        n_tests++; if (sram_addr !== 16'd3) begin n_fail++; $display("FAIL mid_pre_addr got %h need 0003", sram_addr); end
        drop_delay = 6;
        send(8'hC1);
        send(8'hC2);
        cyc(2);
        reset = 1'b1;
        cyc(1);
        @(negedge clk);
        n_tests++; if (sram_start !== 1'b1) begin n_fail++; $display("FAIL mid_start got %b need 1", sram_start); end
        n_tests++; if (sram_addr !== 16'h0) begin n_fail++; $display("FAIL mid_addr got %h need 0000", sram_addr); end
        cyc(1);
        reset      = 1'b0;
        drop_delay = 0;
        cyc(15);
        n_tests++; if (sw_cnt != 0) begin n_fail++; $display("FAIL mid_no_switch got %0d need 0", sw_cnt); end
        wr_addr_q.delete();
        wr_data_q.delete();
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        send(b0);
        send(b1);
        wait_wr(1, 30, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL mid_timeout got no write need 1 write"); end
        cyc(15);
        if (wr_data_q.size() >= 1) begin
            n_tests++; if (wr_data_q[0] !== {b0, b1} || wr_addr_q[0] !== 16'd0) begin
                n_fail++; $display("FAIL mid_next_pair got %h@%h need %h@0000", wr_data_q[0], wr_addr_q[0], {b0, b1});
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_rotation();
        test_random();
        test_back_to_back();
        test_overflow();
        test_flush();
        test_reset_mid();
        n_tests++; if (proto_err != 0) begin n_fail++; $display("FAIL start_while_busy got %0d need 0", proto_err); end
        n_tests++; if (sw_wide != 0) begin n_fail++; $display("FAIL switch_width got %0d wide pulses need 0", sw_wide); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
